// File: rtl/alu_pkg.sv
// Shared constants for the RV64I integer execute block: opcodes, ALU select
// and branch-class encodings, plus a sign-extension helper for W-ops.
// Optional feature macro: ALU_MUL_EN (enables mul/mulw decode in alu_decode).
package alu_pkg;

  // Datapath width; W-ops assume a 32-bit lower half, so only 64 is supported.
  localparam int XLEN = 64;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPW      = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;

  // funct7 value of the M-extension group (only mul/mulw are implemented)
  localparam logic [6:0] F7_MULDIV    = 7'b0000001;

  typedef enum logic [2:0] {
    SEL_ADD  = 3'b000,  // add / sub
    SEL_SLL  = 3'b001,
    SEL_SLT  = 3'b010,
    SEL_SLTU = 3'b011,
    SEL_XOR  = 3'b100,
    SEL_SR   = 3'b101,  // srl / sra
    SEL_OR   = 3'b110,
    SEL_AND  = 3'b111
  } sel_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_LT   = 3'b011,
    BR_GE   = 3'b100,
    BR_LTU  = 3'b101,
    BR_GEU  = 3'b110,
    BR_RSVD = 3'b111
  } br_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_branch_unit_if.sv
// Operand/result bundle between the core control path and alu_branch_unit.
// master: drives instr, in1, in2, branch_src; receives out and flags.
// slave : the execute unit; results are registered, one cycle after inputs.
interface alu_branch_unit_if;
  import alu_pkg::*;

  logic [31:0]     instr;       // current instruction
  logic [XLEN-1:0] in1;         // rs1
  logic [XLEN-1:0] in2;         // rs2 or immediate, already muxed
  logic [2:0]      branch_src;  // branch class from main control
  logic [XLEN-1:0] out;         // registered ALU result
  logic            zero;        // registered in1 == in2
  logic            neg;         // registered signed in1 < in2
  logic            negu;        // registered unsigned in1 < in2
  logic            branch;      // registered branch-taken

  modport master (
    output instr, in1, in2, branch_src,
    input  out, zero, neg, negu, branch
  );

  modport slave (
    input  instr, in1, in2, branch_src,
    output out, zero, neg, negu, branch
  );

endinterface

// File: rtl/alu_decode.sv
// Purpose: instruction fields -> ALU select / alt (sub, sra) / word (W-op).
// Latency: purely combinational. Backpressure: none.
// Ports: opcode_i, funct3_i, funct7_i in; select_o, alt_o, word_o (+ mext_o with ALU_MUL_EN) out.
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output sel_e       select_o,
  output logic       alt_o,
  output logic       word_o
`ifdef ALU_MUL_EN
  ,
  output logic       mext_o
`endif
);

`ifndef ALU_MUL_EN
  // Without the multiplier only instr[30] of funct7 carries meaning.
  logic funct7_unused;
  assign funct7_unused = ^{funct7_i[6], funct7_i[4:0]};
`endif

  always_comb begin
    select_o = SEL_ADD;
    alt_o    = 1'b0;
    word_o   = 1'b0;
`ifdef ALU_MUL_EN
    mext_o   = 1'b0;
`endif
    unique case (opcode_i)
      OPC_OP, OPC_OPW: begin
        select_o = sel_e'(funct3_i);
        alt_o    = funct7_i[5] && (funct3_i == 3'b000 || funct3_i == 3'b101);
        word_o   = (opcode_i == OPC_OPW);
`ifdef ALU_MUL_EN
        mext_o   = (funct7_i == F7_MULDIV);
`endif
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        // No subi: instr[30] is part of the immediate except for shifts right.
        select_o = sel_e'(funct3_i);
        alt_o    = funct7_i[5] && (funct3_i == 3'b101);
        word_o   = (opcode_i == OPC_OP_IMM32);
      end
      OPC_BRANCH: begin
        select_o = SEL_ADD;
        alt_o    = 1'b1;
      end
      default: ;  // loads, stores, jumps, lui, auipc, system: plain add
    endcase
  end

endmodule

// File: rtl/alu_branch_unit.sv
// Purpose: RV64I integer ALU, compare flags and branch-taken resolution.
// Latency: one cycle, all outputs registered. Backpressure: none, captures every clock.
// Ports: clk, rst_n (sync, active-low); bus (alu_branch_unit_if.slave). Optional macro: ALU_MUL_EN.
module alu_branch_unit
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  alu_branch_unit_if.slave    bus
);

  sel_e            sel;
  logic            alt;
  logic            word;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [5:0]      shamt;
  logic [XLEN-1:0] sh_src;
  logic [XLEN-1:0] res;

  logic [XLEN-1:0] out_d, out_q;
  logic            zero_d, zero_q;
  logic            neg_d, neg_q;
  logic            negu_d, negu_q;
  logic            branch_d, branch_q;

  // Register and immediate fields are handled upstream.
  logic instr_unused;
  assign instr_unused = ^{bus.instr[24:15], bus.instr[11:7]};

  assign in1 = bus.in1;
  assign in2 = bus.in2;

`ifdef ALU_MUL_EN
  logic mext;
`endif

  alu_decode u_decode (
    .opcode_i (bus.instr[6:0]),
    .funct3_i (bus.instr[14:12]),
    .funct7_i (bus.instr[31:25]),
    .select_o (sel),
    .alt_o    (alt),
    .word_o   (word)
`ifdef ALU_MUL_EN
    ,
    .mext_o   (mext)
`endif
  );

  // Flags depend only on the operands, never on the operation.
  assign zero_d = (in1 == in2);
  assign neg_d  = ($signed(in1) < $signed(in2));
  assign negu_d = (in1 < in2);

  // W-shifts use a 5-bit amount on the low word; the right-shift source is
  // pre-extended so sraw fills from bit 31 and srlw fills with zeros.
  assign shamt  = word ? {1'b0, in2[4:0]} : in2[5:0];
  assign sh_src = word ? (alt ? sext32(in1[31:0]) : {32'b0, in1[31:0]}) : in1;

  always_comb begin
    res = '0;
    unique case (sel)
      SEL_ADD:  res = alt ? (in1 - in2) : (in1 + in2);
      SEL_SLL:  res = in1 << shamt;
      SEL_SLT:  res = {63'b0, neg_d};
      SEL_SLTU: res = {63'b0, negu_d};
      SEL_XOR:  res = in1 ^ in2;
      SEL_SR:   res = alt ? $unsigned($signed(sh_src) >>> shamt) : (sh_src >> shamt);
      SEL_OR:   res = in1 | in2;
      SEL_AND:  res = in1 & in2;
      default:  res = '0;
    endcase
`ifdef ALU_MUL_EN
    // Only mul/mulw exist; the rest of the M group returns zero.
    if (mext) begin
      res = (sel == SEL_ADD) ? (in1 * in2) : '0;
    end
`endif
  end

  // Every W encoding, legal or not, yields the sign-extended low word.
  assign out_d = word ? sext32(res[31:0]) : res;

  always_comb begin
    branch_d = 1'b0;
    unique case (br_e'(bus.branch_src))
      BR_EQ:   branch_d = zero_d;
      BR_NE:   branch_d = !zero_d;
      BR_LT:   branch_d = neg_d;
      BR_GE:   branch_d = !neg_d;
      BR_LTU:  branch_d = negu_d;
      BR_GEU:  branch_d = !negu_d;
      default: branch_d = 1'b0;  // none and reserved
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      negu_q   <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      negu_q   <= negu_d;
      branch_q <= branch_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;
  assign bus.negu   = negu_q;
  assign bus.branch = branch_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed bench for alu_branch_unit: reset, arithmetic, W-ops, shifts,
// flags and every branch class, with hand-computed expectations.
module tb_alu_branch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_branch_unit_if bus ();

  alu_branch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge capture, sample 1ns later.
  task automatic apply(input logic [31:0] instr, input logic [63:0] a,
                       input logic [63:0] b, input logic [2:0] bs);
    @(negedge clk);
    bus.instr      = instr;
    bus.in1        = a;
    bus.in2        = b;
    bus.branch_src = bs;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] bs;
    logic       exp;
    string      tag;
  } br_vec_t;

  br_vec_t br_tab[8];

  initial begin
    bus.instr      = 32'h0;
    bus.in1        = 64'd0;
    bus.in2        = 64'd0;
    bus.branch_src = 3'b000;

    // Reset clears all outputs even though the inputs would set zero/branch.
    rst_n = 1'b0;
    apply(32'h0000_0000, 64'd5, 64'd5, 3'b001);
    check("rst_out",    bus.out,    64'd0);
    check("rst_zero",   {63'b0, bus.zero},   64'd0);
    check("rst_neg",    {63'b0, bus.neg},    64'd0);
    check("rst_negu",   {63'b0, bus.negu},   64'd0);
    check("rst_branch", {63'b0, bus.branch}, 64'd0);

    // First edge after release captures normally (opcode 0 -> add).
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_zero",   {63'b0, bus.zero},   64'd1);
    check("post_rst_branch", {63'b0, bus.branch}, 64'd1);
    check("post_rst_out",    bus.out,             64'd10);

    // sub 3-5, and confirm the output only moves at the clock edge.
    @(negedge clk);
    bus.instr = 32'h4000_0033; bus.in1 = 64'd3; bus.in2 = 64'd5; bus.branch_src = 3'b000;
    #1;
    check("latency_hold", bus.out, 64'd10);
    @(posedge clk);
    #1;
    check("sub_out",  bus.out, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_neg",  {63'b0, bus.neg},  64'd1);
    check("sub_negu", {63'b0, bus.negu}, 64'd1);
    check("sub_zero", {63'b0, bus.zero}, 64'd0);

    apply(32'h0000_003B, 64'h7FFF_FFFF, 64'd1, 3'b000);
    check("addw", bus.out, 64'hFFFF_FFFF_8000_0000);
    apply(32'h4010_501B, 64'h8000_0000, 64'd1, 3'b000);
    check("sraiw", bus.out, 64'hFFFF_FFFF_C000_0000);

    // Branch classes with in1=-1, in2=1 (signed less, unsigned greater).
    br_tab[0] = '{3'b011, 1'b1, "blt"};
    br_tab[1] = '{3'b101, 1'b0, "bltu"};
    br_tab[2] = '{3'b100, 1'b0, "bge"};
    br_tab[3] = '{3'b110, 1'b1, "bgeu"};
    br_tab[4] = '{3'b010, 1'b1, "bne"};
    br_tab[5] = '{3'b001, 1'b0, "beq"};
    br_tab[6] = '{3'b000, 1'b0, "br_none"};
    br_tab[7] = '{3'b111, 1'b0, "br_rsvd"};
    for (int i = 0; i < 8; i++) begin
      apply(32'h0000_0063, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, br_tab[i].bs);
      check(br_tab[i].tag, {63'b0, bus.branch}, {63'b0, br_tab[i].exp});
    end
    check("branch_sub_out", bus.out, 64'hFFFF_FFFF_FFFF_FFFE);

    // Shifts: amount 63, upper amount bits ignored.
    apply(32'h0000_1033, 64'd1, 64'h7F, 3'b000);
    check("sll63", bus.out, 64'h8000_0000_0000_0000);
    apply(32'h0000_3033, 64'd1, 64'd2, 3'b000);
    check("sltu", bus.out, 64'd1);
    apply(32'h0000_2033, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000);
    check("slt_signed", bus.out, 64'd1);
    apply(32'h4000_5033, 64'h8000_0000_0000_0000, 64'd4, 3'b000);
    check("sra_fill", bus.out, 64'hF800_0000_0000_0000);
    apply(32'h0000_5033, 64'h8000_0000_0000_0000, 64'd4, 3'b000);
    check("srl_fill", bus.out, 64'h0800_0000_0000_0000);
    apply(32'h0000_103B, 64'd1, 64'h3F, 3'b000);
    check("sllw31", bus.out, 64'hFFFF_FFFF_8000_0000);
    apply(32'h0000_503B, 64'hFFFF_FFFF_8000_0000, 64'd31, 3'b000);
    check("srlw31", bus.out, 64'd1);

    // Add overflow wraps; OP-IMM with instr[30] set is still add.
    apply(32'h0000_0033, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b000);
    check("add_wrap", bus.out, 64'h8000_0000_0000_0000);
    apply(32'h4000_0013, 64'd5, 64'd3, 3'b000);
    check("no_subi", bus.out, 64'd8);
    apply(32'h0000_6033, 64'hF0F0, 64'h0F0F, 3'b000);
    check("or", bus.out, 64'hFFFF);
    apply(32'h0000_7033, 64'hFF00, 64'h0FF0, 3'b000);
    check("and", bus.out, 64'h0F00);
    apply(32'h0000_4033, 64'hFF00, 64'h0FF0, 3'b000);
    check("xor", bus.out, 64'hF0F0);

`ifdef ALU_MUL_EN
    apply(32'h0200_0033, 64'd6, 64'd7, 3'b000);
    check("mul", bus.out, 64'd42);
`else
    apply(32'h0200_0033, 64'd6, 64'd7, 3'b000);
    check("mul_as_add", bus.out, 64'd13);
`endif

    // Reset asserted mid-stream clears, release captures on the next edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out", bus.out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h4000_0033, 64'd9, 64'd4, 3'b001);
    check("midrst_release_out", bus.out, 64'd5);
    check("midrst_release_br", {63'b0, bus.branch}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
